// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral register bus between two masters.
// Each access runs IDLE -> ISSUE (one-cycle strobe) -> CAPTURE (registered ack/err/rdata).
module periph_bus_arbiter #(
    parameter logic [31:0] ADDR_BASE = 32'h4000_0000,
    parameter logic [31:0] ADDR_SPAN = 32'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_r_acc,
    input  logic        bus_w_acc
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic        r_owner;
    logic        r_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_m0_ack;
    logic        r_m0_err;
    logic        r_m1_ack;
    logic        r_m1_err;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    logic        w_req0;
    logic        w_req1;
    logic        w_grant;
    logic        w_sel;
    logic        w_rd;
    logic        w_wr;
    logic        w_gnt0;
    logic        w_gnt1;
    logic [31:0] w_off;
    logic        w_bad;
    logic        w_acc;
    logic        w_ok;

    // A master is still dropping its request in the cycle it sees ack/err.
    assign w_req0 = m0_req & ~r_m0_ack & ~r_m0_err;
    assign w_req1 = m1_req & ~r_m1_ack & ~r_m1_err;

    // Offset wraps to a huge value below ADDR_BASE, so one compare covers both bounds.
    assign w_off = r_addr - ADDR_BASE;
    assign w_bad = (w_off >= ADDR_SPAN) || (r_addr[1:0] != 2'b00);
    assign w_acc = r_wr ? bus_w_acc : bus_r_acc;
    assign w_ok  = ~w_bad & w_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_sel   = 1'b0;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_grant = 1'b1;
                    w_sel   = (w_req0 && w_req1) ? ~r_last : w_req1;
                    w_next  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_gnt0 = ~r_owner;
                w_gnt1 = r_owner;
                if (!w_bad) begin
                    w_rd = ~r_wr;
                    w_wr = r_wr;
                end
                w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_gnt0 = ~r_owner;
                w_gnt1 = r_owner;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_m0_ack   <= 1'b0;
            r_m0_err   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m1_err   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m0_err <= 1'b0;
            r_m1_ack <= 1'b0;
            r_m1_err <= 1'b0;
            if (w_grant) begin
                r_owner <= w_sel;
                r_last  <= w_sel;
                r_wr    <= w_sel ? m1_wr    : m0_wr;
                r_addr  <= w_sel ? m1_addr  : m0_addr;
                r_wdata <= w_sel ? m1_wdata : m0_wdata;
            end
            if (r_state == S_CAPTURE) begin
                if (r_owner == 1'b0) begin
                    r_m0_ack <= w_ok;
                    r_m0_err <= ~w_ok;
                    if (w_ok && !r_wr) begin
                        r_m0_rdata <= bus_rdata;
                    end
                end else begin
                    r_m1_ack <= w_ok;
                    r_m1_err <= ~w_ok;
                    if (w_ok && !r_wr) begin
                        r_m1_rdata <= bus_rdata;
                    end
                end
            end
        end
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_ack    = r_m0_ack;
    assign m0_err    = r_m0_err;
    assign m1_ack    = r_m1_ack;
    assign m1_err    = r_m1_err;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign bus_rd    = w_rd;
    assign bus_wr    = w_wr;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: stimulus queues expected bus strobes and
// master responses; a negedge monitor pops and compares whenever the DUT shows one.
`timescale 1ns/1ps
module tb_periph_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_wr = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m1_req = 1'b0, m1_wr = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_rd, bus_wr;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_r_acc = 1'b0, bus_w_acc = 1'b0;

    logic [31:0] p_rdata = '0;
    logic        p_racc = 1'b0, p_wacc = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;
    typedef struct {
        bit          m;
        bit          err;
        logic [31:0] rdata;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];

    periph_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_r_acc(bus_r_acc), .bus_w_acc(bus_w_acc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral model: registers data and access flags at the strobe edge.
    always @(posedge clk) begin
        if (bus_rd || bus_wr) begin
            bus_rdata <= p_rdata;
            bus_r_acc <= p_racc;
            bus_w_acc <= p_wacc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bus_t  b;
        resp_t r;
        bit    m;
        bit    e;
        if (m0_gnt || m1_gnt) chk("gnt_exclusive", {63'd0, m0_gnt & m1_gnt}, 64'd0);
        if (bus_rd || bus_wr) begin
            chk("strobe_exclusive", {63'd0, bus_rd & bus_wr}, 64'd0);
            if (bus_q.size() == 0) begin
                chk("bus_unexpected", {31'd0, bus_wr, bus_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                b = bus_q.pop_front();
                chk("bus_kind_addr", {31'd0, bus_wr, bus_addr}, {31'd0, b.wr, b.addr});
                chk("bus_wdata", {32'd0, bus_wdata}, {32'd0, b.wdata});
            end
        end
        if (m0_ack || m0_err || m1_ack || m1_err) begin
            chk("resp_one_master", {63'd0, (m0_ack | m0_err) & (m1_ack | m1_err)}, 64'd0);
            chk("ack_err_exclusive", {62'd0, m0_ack & m0_err, m1_ack & m1_err}, 64'd0);
            m = m1_ack | m1_err;
            e = m ? m1_err : m0_err;
            if (resp_q.size() == 0) begin
                chk("resp_unexpected", {62'd0, m, e}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                r = resp_q.pop_front();
                chk("resp_master_err", {62'd0, m, e}, {62'd0, r.m, r.err});
                chk("resp_rdata", {32'd0, m ? m1_rdata : m0_rdata}, {32'd0, r.rdata});
            end
        end
    end

    task automatic drive(input int m, input bit req, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_req = req; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    // Request, wait for ack/err (bounded), optionally check latency, then drop req.
    task automatic txn(input int m, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit chk_lat);
        int  k;
        bit  done;
        @(posedge clk); #1;
        k = cyc;
        drive(m, 1'b1, wr, addr, wdata);
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (m == 0 ? (m0_ack | m0_err) : (m1_ack | m1_err)) done = 1'b1;
        end
        if (!done) chk("txn_timeout", 64'd0, 64'd1);
        else if (chk_lat) chk("latency", 64'(cyc - k), 64'd3);
        @(posedge clk); #1;
        drive(m, 1'b0, wr, addr, wdata);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {56'd0, m0_gnt, m1_gnt, m0_ack, m0_err, m1_ack, m1_err, bus_rd, bus_wr}, 64'd0);
        chk({tag, "_bus"}, {bus_addr, bus_wdata}, 64'd0);
        chk({tag, "_rdata"}, {m0_rdata, m1_rdata}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk_all_zero("reset_state");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Single read, m0
        p_rdata = 32'h0000_00A5; p_racc = 1'b1; p_wacc = 1'b1;
        bus_q.push_back('{1'b0, 32'h4000_0014, 32'h0});
        resp_q.push_back('{1'b0, 1'b0, 32'h0000_00A5});
        txn(0, 1'b0, 32'h4000_0014, 32'h0, 1'b1);

        // Single write, m1
        bus_q.push_back('{1'b1, 32'h4000_0010, 32'h0000_003C});
        resp_q.push_back('{1'b1, 1'b0, 32'h0});
        txn(1, 1'b1, 32'h4000_0010, 32'h0000_003C, 1'b1);
        repeat (2) @(posedge clk);
        #1 chk("bus_hold", {bus_addr, bus_wdata}, {32'h4000_0010, 32'h0000_003C});

        // Contention: both request together, grants alternate starting with m0
        p_rdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            bus_q.push_back('{1'b0, 32'h4000_0000 + 32'(4 * i), 32'h0});
            resp_q.push_back('{1'b0, 1'b0, 32'h1234_5678});
            bus_q.push_back('{1'b1, 32'h4000_0018, 32'(i + 1)});
            resp_q.push_back('{1'b1, 1'b0, 32'h0});
        end
        fork
            begin
                for (int i = 0; i < 4; i++) txn(0, 1'b0, 32'h4000_0000 + 32'(4 * i), 32'h0, 1'b0);
            end
            begin
                for (int j = 0; j < 4; j++) txn(1, 1'b1, 32'h4000_0018, 32'(j + 1), 1'b0);
            end
        join

        // Bad addresses: no strobe, err, rdata unchanged
        resp_q.push_back('{1'b0, 1'b1, 32'h1234_5678});
        txn(0, 1'b0, 32'h4000_0040, 32'h0, 1'b1);
        resp_q.push_back('{1'b0, 1'b1, 32'h1234_5678});
        txn(0, 1'b0, 32'h4000_0002, 32'h0, 1'b1);
        resp_q.push_back('{1'b0, 1'b1, 32'h1234_5678});
        txn(0, 1'b0, 32'h4000_0020, 32'h0, 1'b1);
        resp_q.push_back('{1'b0, 1'b1, 32'h1234_5678});
        txn(0, 1'b0, 32'h3FFF_FFFC, 32'h0, 1'b1);

        // Top legal word
        p_rdata = 32'h0000_0055;
        bus_q.push_back('{1'b0, 32'h4000_001C, 32'h0});
        resp_q.push_back('{1'b0, 1'b0, 32'h0000_0055});
        txn(0, 1'b0, 32'h4000_001C, 32'h0, 1'b1);

        // Not accessible: strobe issued, err, no ack
        p_racc = 1'b0; p_wacc = 1'b1; p_rdata = 32'hDEAD_BEEF;
        bus_q.push_back('{1'b0, 32'h4000_001C, 32'h0});
        resp_q.push_back('{1'b1, 1'b1, 32'h0});
        txn(1, 1'b0, 32'h4000_001C, 32'h0, 1'b1);
        p_racc = 1'b1; p_wacc = 1'b0;
        bus_q.push_back('{1'b1, 32'h4000_0000, 32'h0000_0077});
        resp_q.push_back('{1'b1, 1'b1, 32'h0});
        txn(1, 1'b1, 32'h4000_0000, 32'h0000_0077, 1'b1);

        // Reset during ISSUE of an m0 write
        p_wacc = 1'b1;
        bus_q.push_back('{1'b1, 32'h4000_0004, 32'h0000_DEAD});
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h4000_0004, 32'h0000_DEAD);
        @(posedge clk);
        @(negedge clk);
        chk("issue_wr_before_reset", {62'd0, bus_wr, m0_gnt}, 64'd3);
        #2 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
        chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
